// File: rtl/pipe_pkg.sv
// Shared types and per-stage bundle widths for the core's pipeline registers.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FULL    = 2'd1,
        SKIDDED = 2'd2
    } state_t;

    // IF/ID: predicted_taken | instr, pc, pc_plus_4
    localparam int unsigned IFID_CTRL_W  = 1;
    localparam int unsigned IFID_DATA_W  = 96;
    // ID/EX: reg_write, result_src[1:0], mem_write, jump, branch, alu_src, alu_ctrl | rd1, rd2, pc, imm, pc_plus_4, rs1, rs2, rd
    localparam int unsigned IDEX_CTRL_W  = 8;
    localparam int unsigned IDEX_DATA_W  = 175;
    // EX/MEM: reg_write, result_src[1:0], mem_write | alu_result, write_data, pc_plus_4, rd
    localparam int unsigned EXMEM_CTRL_W = 4;
    localparam int unsigned EXMEM_DATA_W = 101;
    // MEM/WB: reg_write, result_src[1:0] | alu_result, read_data, pc_plus_4, rd
    localparam int unsigned MEMWB_CTRL_W = 3;
    localparam int unsigned MEMWB_DATA_W = 101;

    // Total width of one stored entry (control and data packed side by side).
    function automatic int unsigned entry_w(input int unsigned ctrl_w, input int unsigned data_w);
        return ctrl_w + data_w;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_entry.sv
// One storage slot of a stage register: load enable, synchronous clear, async reset.
module pipe_entry #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Clear wins over load so a flush never lets a new entry slip in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage register with valid/ready handshake, flush and optional skid slot.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = EXMEM_CTRL_W,
    parameter int unsigned DATA_W = EXMEM_DATA_W,
    parameter bit          SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
);

    localparam int unsigned ENTRY_W = entry_w(CTRL_W, DATA_W);

    state_t               state;
    state_t               state_nxt;
    logic                 main_load;
    logic                 skid_load;
    logic                 main_from_skid;
    logic                 clear;
    logic [ENTRY_W-1:0]   in_entry;
    logic [ENTRY_W-1:0]   main_d;
    logic [ENTRY_W-1:0]   main_q;
    logic [ENTRY_W-1:0]   skid_q;

    assign in_entry = {in_ctrl, in_data};

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and slot load controls; flush overrides every other event.
    always_comb begin
        state_nxt      = state;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        clear          = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
            clear     = 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_valid) begin
                        main_load = 1'b1;
                        state_nxt = FULL;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            main_load = 1'b1;
                        end else begin
                            state_nxt = EMPTY;
                        end
                    end else if (in_valid && SKID) begin
                        skid_load = 1'b1;
                        state_nxt = SKIDDED;
                    end
                end
                SKIDDED: begin
                    if (out_ready) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        state_nxt      = FULL;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                end
            endcase
        end
    end

    // With a skid slot, in_ready depends on registered state only.
    assign in_ready = SKID ? (state != SKIDDED)
                           : ((state == EMPTY) || out_ready);

    assign main_d = main_from_skid ? skid_q : in_entry;

    pipe_entry #(.W(ENTRY_W)) u_main (
        .clk   (clk),
        .reset (reset),
        .load  (main_load),
        .clear (clear),
        .d     (main_d),
        .q     (main_q)
    );

    generate
        if (SKID) begin : g_skid
            pipe_entry #(.W(ENTRY_W)) u_skid (
                .clk   (clk),
                .reset (reset),
                .load  (skid_load),
                .clear (clear),
                .d     (in_entry),
                .q     (skid_q)
            );
        end else begin : g_no_skid
            assign skid_q = '0;
        end
    endgenerate

    // Bubbles carry no control so write-enables cannot leak downstream.
    assign out_valid = (state != EMPTY);
    assign out_ctrl  = main_q[ENTRY_W-1 -: CTRL_W] & {CTRL_W{out_valid}};
    assign out_data  = main_q[DATA_W-1:0];

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed checks of pipe_stage_reg with and without the skid slot.
module tb_pipe_stage_reg;

    logic          clk;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          out_ready;
    logic [3:0]    in_ctrl;
    logic [100:0]  in_data;

    logic          in_ready1, out_valid1;
    logic [3:0]    out_ctrl1;
    logic [100:0]  out_data1;
    logic          in_ready0, out_valid0;
    logic [3:0]    out_ctrl0;
    logic [100:0]  out_data0;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_stage_reg #(.CTRL_W(4), .DATA_W(101), .SKID(1'b1)) dut1 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_ctrl(out_ctrl1), .out_data(out_data1)
    );

    pipe_stage_reg #(.CTRL_W(4), .DATA_W(101), .SKID(1'b0)) dut0 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_ctrl(out_ctrl0), .out_data(out_data0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs are driven and outputs sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 4'hF; in_data = 101'h11;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid1: got %0b want 0", out_valid1); end
        n_checks++; if (out_ctrl1 !== 4'h0) begin n_fail++; $display("FAIL reset_out_ctrl1: got %h want 0", out_ctrl1); end
        n_checks++; if (out_data1 !== 101'h0) begin n_fail++; $display("FAIL reset_out_data1: got %h want 0", out_data1); end
        n_checks++; if (in_ready1 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready1: got %0b want 1", in_ready1); end
        n_checks++; if (in_ready0 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready0: got %0b want 1", in_ready0); end
        n_checks++; if (out_valid0 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid0: got %0b want 0", out_valid0); end
        reset = 1'b0;
        step();
        n_checks++; if (out_valid1 !== 1'b1) begin n_fail++; $display("FAIL first_load_valid1: got %0b want 1", out_valid1); end
        n_checks++; if (out_ctrl1 !== 4'hF) begin n_fail++; $display("FAIL first_load_ctrl1: got %h want f", out_ctrl1); end
        n_checks++; if (out_data1 !== 101'h11) begin n_fail++; $display("FAIL first_load_data1: got %h want 11", out_data1); end
        n_checks++; if (out_ctrl0 !== 4'hF) begin n_fail++; $display("FAIL first_load_ctrl0: got %h want f", out_ctrl0); end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        n_checks++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL drain_valid1: got %0b want 0", out_valid1); end
    endtask

    task automatic test_streaming();
        logic [100:0] vals [3];
        vals[0] = 101'd1; vals[1] = 101'd2; vals[2] = 101'd3;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_ctrl = 4'h1; in_data = vals[i];
            n_checks++; if (in_ready1 !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready1[%0d]: got %0b want 1", i, in_ready1); end
            n_checks++; if (in_ready0 !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready0[%0d]: got %0b want 1", i, in_ready0); end
            step();
            n_checks++; if (out_data1 !== vals[i] || out_valid1 !== 1'b1) begin n_fail++; $display("FAIL stream_out1[%0d]: got v=%0b d=%0d want v=1 d=%0d", i, out_valid1, out_data1, vals[i]); end
            n_checks++; if (out_data0 !== vals[i] || out_valid0 !== 1'b1) begin n_fail++; $display("FAIL stream_out0[%0d]: got v=%0b d=%0d want v=1 d=%0d", i, out_valid0, out_data0, vals[i]); end
        end
        in_valid = 1'b0;
        step();
        n_checks++; if (out_valid1 !== 1'b0 || out_valid0 !== 1'b0) begin n_fail++; $display("FAIL stream_drain: got %0b/%0b want 0/0", out_valid1, out_valid0); end
    endtask

    task automatic test_skid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 4'h1; in_data = 101'd5;
        step();
        in_ctrl = 4'h2; in_data = 101'd6;
        n_checks++; if (in_ready1 !== 1'b1) begin n_fail++; $display("FAIL skid_accept_ready: got %0b want 1", in_ready1); end
        step();
        in_valid = 1'b0;
        n_checks++; if (in_ready1 !== 1'b0) begin n_fail++; $display("FAIL skidded_in_ready: got %0b want 0", in_ready1); end
        n_checks++; if (out_data1 !== 101'd5 || out_ctrl1 !== 4'h1) begin n_fail++; $display("FAIL skidded_out: got d=%0d c=%h want d=5 c=1", out_data1, out_ctrl1); end
        step();
        n_checks++; if (out_data1 !== 101'd5 || in_ready1 !== 1'b0) begin n_fail++; $display("FAIL skidded_hold: got d=%0d r=%0b want d=5 r=0", out_data1, in_ready1); end
        out_ready = 1'b1;
        step();
        n_checks++; if (out_data1 !== 101'd6 || out_ctrl1 !== 4'h2 || out_valid1 !== 1'b1) begin n_fail++; $display("FAIL skid_second: got v=%0b d=%0d c=%h want v=1 d=6 c=2", out_valid1, out_data1, out_ctrl1); end
        n_checks++; if (in_ready1 !== 1'b1) begin n_fail++; $display("FAIL skid_release_ready: got %0b want 1", in_ready1); end
        step();
        n_checks++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL skid_no_dup: got %0b want 0", out_valid1); end
        step();
    endtask

    task automatic test_stall_noskid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 4'h3; in_data = 101'd8;
        step();
        in_ctrl = 4'h4; in_data = 101'd7;
        n_checks++; if (in_ready0 !== 1'b0) begin n_fail++; $display("FAIL noskid_stall_ready: got %0b want 0", in_ready0); end
        step();
        n_checks++; if (out_data0 !== 101'd8 || in_ready0 !== 1'b0) begin n_fail++; $display("FAIL noskid_hold: got d=%0d r=%0b want d=8 r=0", out_data0, in_ready0); end
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready0 !== 1'b1) begin n_fail++; $display("FAIL noskid_comb_ready: got %0b want 1", in_ready0); end
        step();
        n_checks++; if (out_data0 !== 101'd7 || out_ctrl0 !== 4'h4) begin n_fail++; $display("FAIL noskid_release: got d=%0d c=%h want d=7 c=4", out_data0, out_ctrl0); end
        in_valid = 1'b0;
        step();
        step();
        n_checks++; if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin n_fail++; $display("FAIL noskid_drain: got %0b/%0b want 0/0", out_valid0, out_valid1); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 4'h1; in_data = 101'h21;
        step();
        in_ctrl = 4'h2; in_data = 101'h22;
        step();
        in_ctrl = 4'hF; in_data = 101'd9; flush = 1'b1;
        n_checks++; if (out_valid1 !== 1'b1 || in_ready1 !== 1'b0) begin n_fail++; $display("FAIL flush_cycle_state: got v=%0b r=%0b want v=1 r=0", out_valid1, in_ready1); end
        step();
        flush = 1'b0; in_valid = 1'b0;
        n_checks++; if (out_valid1 !== 1'b0 || out_ctrl1 !== 4'h0 || out_data1 !== 101'h0) begin n_fail++; $display("FAIL flush_clear1: got v=%0b c=%h d=%h want 0/0/0", out_valid1, out_ctrl1, out_data1); end
        n_checks++; if (in_ready1 !== 1'b1) begin n_fail++; $display("FAIL flush_ready1: got %0b want 1", in_ready1); end
        n_checks++; if (out_valid0 !== 1'b0 || out_data0 !== 101'h0) begin n_fail++; $display("FAIL flush_clear0: got v=%0b d=%h want 0/0", out_valid0, out_data0); end
        out_ready = 1'b1;
        step();
        n_checks++; if (out_valid1 !== 1'b0 || out_data1 !== 101'h0) begin n_fail++; $display("FAIL flush_skid_gone: got v=%0b d=%h want 0/0", out_valid1, out_data1); end
    endtask

    task automatic test_bubble();
        out_ready = 1'b1;
        in_valid = 1'b1; in_ctrl = 4'b1011; in_data = 101'h55;
        step();
        n_checks++; if (out_ctrl1 !== 4'b1011 || out_valid1 !== 1'b1) begin n_fail++; $display("FAIL bubble_load: got v=%0b c=%b want v=1 c=1011", out_valid1, out_ctrl1); end
        in_valid = 1'b0;
        step();
        n_checks++; if (out_valid1 !== 1'b0 || out_ctrl1 !== 4'h0) begin n_fail++; $display("FAIL bubble_ctrl1: got v=%0b c=%b want v=0 c=0000", out_valid1, out_ctrl1); end
        n_checks++; if (out_data1 !== 101'h55) begin n_fail++; $display("FAIL bubble_data1: got %h want 55", out_data1); end
        n_checks++; if (out_valid0 !== 1'b0 || out_ctrl0 !== 4'h0 || out_data0 !== 101'h55) begin n_fail++; $display("FAIL bubble0: got v=%0b c=%b d=%h want 0/0000/55", out_valid0, out_ctrl0, out_data0); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_skid();
        test_stall_noskid();
        test_flush();
        test_bubble();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register that replaces the fixed, hand-written inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the pipelined RISC-V core. It carries a control bundle and a data bundle between two stages with a valid/ready handshake, synchronous flush and an optional skid entry. Control bits are forced to zero whenever the stage holds a bubble, so write-enables never leak downstream.

## Interface
- CTRL_W, 4, control bundle width (e.g. reg_write, result_src[1:0], mem_write); must be ≥1
- DATA_W, 101, data bundle width (e.g. alu_result, write_data, pc_plus_4, rd); must be ≥1
- SKID, 1, 1 = two-entry stage with a registered in_ready; 0 = single entry with combinational in_ready

- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- flush  in  1  synchronous discard of all held entries (branch mispredict / exception)
- in_valid  in  1  upstream stage presents an entry
- in_ready  out  1  stage accepts the entry this cycle
- in_ctrl  in  CTRL_W  upstream control bundle
- in_data  in  DATA_W  upstream data bundle
- out_valid  out  1  out_ctrl/out_data hold a valid entry
- out_ready  in  1  downstream stage consumes the entry this cycle
- out_ctrl  out  CTRL_W  control bundle; all zeros when out_valid=0
- out_data  out  DATA_W  data bundle; all zeros after reset or flush, otherwise holds the last value

## Operation
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Storage: main entry (drives outputs) and, if SKID=1, a skid entry.
- States: EMPTY, FULL, and SKIDDED (SKID=1 only).
- EMPTY: in_ready=1. A transfer in loads main and moves to FULL.
- FULL, out_ready && in_valid: main is replaced by the new input; stays FULL.
- FULL, out_ready && !in_valid: moves to EMPTY.
- FULL, !out_ready && in_valid:
  - SKID=1: input goes to skid; moves to SKIDDED.
  - SKID=0: in_ready=0; stall.
- FULL, !out_ready && !in_valid: hold.
- SKIDDED: in_ready=0. out_ready copies skid to main and moves to FULL. Otherwise hold.
- in_ready:
  - SKID=1: in_ready = (state != SKIDDED), decoded from registered state only.
  - SKID=0: in_ready = (state==EMPTY) || out_ready.
- flush has highest priority:
  - Next state is EMPTY. Main and skid ctrl/data are cleared to 0.
  - An input presented in the same cycle is dropped.
  - out_valid stays as registered during the flush cycle. The downstream stage must also qualify with flush.
- out_ctrl = main_ctrl & {CTRL_W{out_valid}}.
- No arithmetic. Widths pass through unchanged; no truncation.

## Timing
- Reset values: out_valid=0, out_ctrl=0, out_data=0, state=EMPTY, skid=0. in_ready=1 for both SKID values.
- Latency is 1 cycle: an entry accepted at edge N is visible on out_* after edge N.
- Throughput is 1 entry/cycle while out_ready=1.
- SKID=1 has no combinational path from out_ready to in_ready. SKID=0 has exactly one such path.
- Ordering is strictly FIFO: a skid entry always precedes any newer entry.
- Reset asserted mid-transfer clears state asynchronously. Deassertion is assumed synchronised by the top level.
- flush and out_ready together: the entry is neither consumed nor retained. Downstream logic must treat it as killed.

## Structure
- Shared package pipe_pkg:
  - state enum (EMPTY, FULL, SKIDDED)
  - per-stage bundle width constants (EXMEM_CTRL_W=4, EXMEM_DATA_W=101, etc.) so all four core stages instantiate with named widths
- One natural sub-module, pipe_entry: a CTRL_W+DATA_W register with load enable and synchronous clear. It is instantiated once for main and once for skid (generate on SKID).

## Test plan
- Reset with in_valid=1, in_ctrl=4'hF -> out_valid=0, out_ctrl=0, out_data=0, in_ready=1. The first edge after deassertion loads the entry; out_ctrl=4'hF one cycle later.
- Streaming, out_ready=1, entries A=1,2,3 on consecutive cycles -> out_data=1,2,3 on the following consecutive cycles; in_ready never drops.
- SKID=1, out_ready=0 while sending 5 then 6 -> state SKIDDED, in_ready=0, out_data=5. Raising out_ready yields 5 then 6; no loss or duplication.
- SKID=0, out_ready=0 with out_valid=1 -> in_ready=0 in the same cycle. Upstream entry 7 is held until out_ready=1, then appears next cycle.
- flush in SKIDDED with in_valid=1 (entry 9) -> next cycle out_valid=0, out_ctrl=0, out_data=0, state EMPTY; entry 9 never appears.
- Bubble check: main_ctrl=4'b1011 drained with no new input -> out_valid=0 and out_ctrl=0 while out_data retains its last value.
